// File: rtl/vga_fb_pkg.sv
// Shared timing constants, control codes and resync states for the framebuffer controller.
package vga_fb_pkg;

   localparam int unsigned FB_W       = 160;
   localparam int unsigned FB_H       = 120;
   localparam int unsigned SCALE_LOG2 = 2;
   localparam int unsigned H_ACTIVE   = 640;
   localparam int unsigned V_ACTIVE   = 480;
   localparam int unsigned LINE       = 799;
   localparam int unsigned SCREEN     = 524;
   localparam int unsigned AW         = 15;

   localparam logic [1:0] CTRL_NONE   = 2'b00;
   localparam logic [1:0] CTRL_RESYNC = 2'b11;

   typedef logic [1:0] rs_state_t;
   localparam rs_state_t ST_IDLE = 2'd0;
   localparam rs_state_t ST_R1   = 2'd1;
   localparam rs_state_t ST_R2   = 2'd2;

endpackage

// File: rtl/vga_fb_if.sv
// Host request/response port of the framebuffer controller.
interface vga_fb_if #(
   parameter int unsigned AW = 15
) ();

   logic          host_valid;
   logic          host_ready;
   logic          host_we;
   logic [AW-1:0] host_addr;
   logic [7:0]    host_wdata;
   logic          host_rvalid;
   logic [7:0]    host_rdata;

   modport master (
      output host_valid, host_we, host_addr, host_wdata,
      input  host_ready, host_rvalid, host_rdata
   );

   modport slave (
      input  host_valid, host_we, host_addr, host_wdata,
      output host_ready, host_rvalid, host_rdata
   );

endinterface

// File: rtl/vga_fb_addr.sv
// Block coordinate to linear framebuffer address: y*160 + x as shift-add.
module vga_fb_addr
   import vga_fb_pkg::*;
#(
   parameter int unsigned AW = vga_fb_pkg::AW
) (
   input  logic [9:0]    i_bx,
   input  logic [9:0]    i_by,
   output logic [AW-1:0] o_addr
);

   assign o_addr = AW'(i_by << 7) + AW'(i_by << 5) + AW'(i_bx);

endmodule

// File: rtl/vga_fb_ctrl.sv
// Framebuffer arbiter: display scan-out has priority, host uses free cycles, resync emits 2'b11.
module vga_fb_ctrl
   import vga_fb_pkg::*;
#(
   parameter int unsigned FB_W       = vga_fb_pkg::FB_W,
   parameter int unsigned FB_H       = vga_fb_pkg::FB_H,
   parameter int unsigned SCALE_LOG2 = vga_fb_pkg::SCALE_LOG2,
   parameter int unsigned H_ACTIVE   = vga_fb_pkg::H_ACTIVE,
   parameter int unsigned V_ACTIVE   = vga_fb_pkg::V_ACTIVE,
   parameter int unsigned LINE       = vga_fb_pkg::LINE,
   parameter int unsigned SCREEN     = vga_fb_pkg::SCREEN,
   parameter int unsigned AW         = vga_fb_pkg::AW
) (
   input  logic          clk_pix,
   input  logic          rst_pix,
   input  logic [9:0]    sx,
   input  logic [9:0]    sy,
   input  logic          de,
   output logic [7:0]    pix_data,
   input  logic          cfg_enable,
   input  logic          cfg_resync,
   vga_fb_if.slave       host,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wdata,
   input  logic [7:0]    mem_rdata
);

   rs_state_t     r_state;
   rs_state_t     w_state_d;
   logic [5:0]    r_pix;
   logic          r_cap;
   logic          r_cap_en;
   logic          r_rvalid;
   logic          r_rd_zero;

   logic [9:0]    w_nx;
   logic [9:0]    w_ny;
   logic [9:0]    w_bx;
   logic [9:0]    w_by;
   logic          w_blk_slot;
   logic          w_slot_pos;
   logic          w_norm_fetch;
   logic          w_disp_fetch;
   logic          w_host_acc;
   logic          w_host_in;
   logic [AW-1:0] w_disp_addr;
   logic [AW-1:0] w_max_addr;

   // Next block start: two pixels ahead, or the first block of the next line/frame.
   always_comb begin
      w_nx = sx + 10'd2;
      w_ny = sy;
      if (sx == 10'(LINE - 1)) begin
         w_nx = '0;
         w_ny = (sy == 10'(SCREEN)) ? '0 : sy + 10'd1;
      end
   end

   assign w_bx = w_nx >> SCALE_LOG2;
   assign w_by = w_ny >> SCALE_LOG2;

   assign w_blk_slot   = (sx[1:0] == 2'd2) && (w_nx < 10'(H_ACTIVE)) && (w_ny < 10'(V_ACTIVE));
   assign w_slot_pos   = (r_state == ST_IDLE) && w_blk_slot;
   assign w_norm_fetch = w_slot_pos && cfg_enable;
   assign w_disp_fetch = w_norm_fetch || (r_state == ST_R1);

   vga_fb_addr #(.AW(AW)) u_disp_addr (
      .i_bx   (w_bx),
      .i_by   (w_by),
      .o_addr (w_disp_addr)
   );

   vga_fb_addr #(.AW(AW)) u_max_addr (
      .i_bx   (10'(FB_W - 1)),
      .i_by   (10'(FB_H - 1)),
      .o_addr (w_max_addr)
   );

   assign host.host_ready = (r_state == ST_IDLE) && !w_norm_fetch;
   assign w_host_acc      = host.host_valid && host.host_ready;
   assign w_host_in       = host.host_addr <= w_max_addr;

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (w_disp_fetch) begin
         mem_en   = 1'b1;
         mem_addr = (r_state == ST_R1) ? '0 : w_disp_addr;
      end else if (w_host_acc && w_host_in) begin
         mem_en    = 1'b1;
         mem_we    = host.host_we;
         mem_addr  = host.host_addr;
         mem_wdata = host.host_we ? host.host_wdata : '0;
      end
   end

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         ST_IDLE: if (cfg_resync) w_state_d = ST_R1;
         ST_R1:   w_state_d = ST_R2;
         ST_R2:   w_state_d = ST_IDLE;
         default: w_state_d = ST_IDLE;
      endcase
   end

   // Capture follows every slot position so a disabled slot loads black.
   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         r_state   <= ST_IDLE;
         r_pix     <= '0;
         r_cap     <= 1'b0;
         r_cap_en  <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rd_zero <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_cap     <= w_slot_pos || (r_state == ST_R1);
         r_cap_en  <= cfg_enable;
         r_rvalid  <= w_host_acc && !host.host_we;
         r_rd_zero <= !w_host_in;
         if (r_cap) r_pix <= r_cap_en ? mem_rdata[7:2] : '0;
      end
   end

   assign host.host_rvalid = r_rvalid;
   assign host.host_rdata  = r_rd_zero ? '0 : mem_rdata;

   assign pix_data = {de ? r_pix : 6'd0, (r_state == ST_R2) ? CTRL_RESYNC : CTRL_NONE};

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Directed bench for vga_fb_ctrl: models the RAM and the vga_driver position counters.
module tb_vga_fb_ctrl;

   logic        clk_pix = 1'b0;
   logic        rst_pix;
   logic [9:0]  sx;
   logic [9:0]  sy;
   logic        de;
   logic [7:0]  pix_data;
   logic        cfg_enable;
   logic        cfg_resync;
   logic        mem_en;
   logic        mem_we;
   logic [14:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic [7:0]  ram [0:19199];
   int          checks = 0;
   int          errors = 0;

   vga_fb_if #(.AW(15)) host_if ();

   vga_fb_ctrl dut (
      .clk_pix    (clk_pix),
      .rst_pix    (rst_pix),
      .sx         (sx),
      .sy         (sy),
      .de         (de),
      .pix_data   (pix_data),
      .cfg_enable (cfg_enable),
      .cfg_resync (cfg_resync),
      .host       (host_if),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk_pix = ~clk_pix;

   task automatic drive_pos(input int x, input int y);
      sx = 10'(x);
      sy = 10'(y);
      de = (x < 640) && (y < 480);
   endtask

   // One pixel clock: RAM model, then driver counters (reset to 0,0 on the 2'b11 code).
   task automatic advance();
      logic        en, we, rs;
      logic [14:0] a;
      logic [7:0]  wd;
      int          x, y;
      en = mem_en; we = mem_we; a = mem_addr; wd = mem_wdata;
      rs = (pix_data[1:0] == 2'b11);
      @(posedge clk_pix);
      #1;
      if (en === 1'b1) begin
         if (we) ram[a] = wd;
         mem_rdata = ram[a];
      end
      if (rs) begin
         drive_pos(0, 0);
      end else begin
         x = int'(sx) + 1;
         y = int'(sy);
         if (x > 799) begin
            x = 0;
            y = (y >= 524) ? 0 : y + 1;
         end
         drive_pos(x, y);
      end
      #1;
   endtask

   task automatic host_write(input int a, input logic [7:0] d);
      host_if.host_valid = 1'b1; host_if.host_we = 1'b1;
      host_if.host_addr = 15'(a); host_if.host_wdata = d;
      #1;
      advance();
      host_if.host_valid = 1'b0; host_if.host_we = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst_pix = 1'b1; cfg_enable = 1'b1; cfg_resync = 1'b0; mem_rdata = 8'h00;
      host_if.host_valid = 1'b0; host_if.host_we = 1'b0;
      host_if.host_addr = '0; host_if.host_wdata = '0;
      drive_pos(0, 0);
      #1;
      for (int i = 0; i < 3; i++) advance();
      checks++; if (pix_data !== 8'h00) begin errors++; $display("FAIL reset_pix: got %h want 00", pix_data); end
      checks++; if (host_if.host_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", host_if.host_rvalid); end
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
      checks++; if (host_if.host_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", host_if.host_ready); end
      rst_pix = 1'b0;
      #1;
   endtask

   task automatic test_scanout();
      drive_pos(650, 524);
      host_if.host_valid = 1'b1; host_if.host_we = 1'b1;
      host_if.host_addr = 15'd0; host_if.host_wdata = 8'hFC;
      #1;
      checks++; if (host_if.host_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b want 1", host_if.host_ready); end
      checks++; if ({mem_en, mem_we} !== 2'b11) begin errors++; $display("FAIL wr_strobe: got %b want 11", {mem_en, mem_we}); end
      checks++; if (mem_wdata !== 8'hFC) begin errors++; $display("FAIL wr_data: got %h want fc", mem_wdata); end
      advance();
      host_write(1, 8'h0C);
      host_write(2, 8'h57);
      host_write(160, 8'h30);
      host_write(825, 8'hE0);
      // frame wrap: sx=798 of sy=524 fetches address 0
      drive_pos(796, 524);
      #1;
      advance(); advance();
      checks++; if ({mem_en, mem_we} !== 2'b10) begin errors++; $display("FAIL wrap_strobe: got %b want 10", {mem_en, mem_we}); end
      checks++; if (mem_addr !== 15'd0) begin errors++; $display("FAIL wrap_addr: got %0d want 0", mem_addr); end
      checks++; if (host_if.host_ready !== 1'b0) begin errors++; $display("FAIL wrap_ready: got %b want 0", host_if.host_ready); end
      advance(); advance();
      checks++; if (pix_data !== 8'hFC) begin errors++; $display("FAIL pix_sx0: got %h want fc", pix_data); end
      advance(); advance();
      checks++; if (mem_addr !== 15'd1) begin errors++; $display("FAIL fetch_sx2: got %0d want 1", mem_addr); end
      advance();
      checks++; if (pix_data !== 8'hFC) begin errors++; $display("FAIL pix_sx3: got %h want fc", pix_data); end
      advance();
      checks++; if (pix_data !== 8'h0C) begin errors++; $display("FAIL pix_sx4: got %h want 0c", pix_data); end
      advance(); advance(); advance();
      checks++; if (pix_data !== 8'h0C) begin errors++; $display("FAIL pix_sx7: got %h want 0c", pix_data); end
      advance();
      checks++; if (pix_data !== 8'h54) begin errors++; $display("FAIL pix_lowbits: got %h want 54", pix_data); end
      drive_pos(640, 0);
      #1;
      checks++; if (pix_data !== 8'h00) begin errors++; $display("FAIL pix_blank: got %h want 00", pix_data); end
      drive_pos(636, 3);
      #1;
      advance(); advance();
      checks++; if ({mem_en, host_if.host_ready} !== 2'b01) begin errors++; $display("FAIL inactive_slot: got %b want 01", {mem_en, host_if.host_ready}); end
      drive_pos(796, 3);
      #1;
      advance(); advance();
      checks++; if (mem_addr !== 15'd160) begin errors++; $display("FAIL line_wrap_addr: got %0d want 160", mem_addr); end
      advance(); advance();
      checks++; if (pix_data !== 8'h30) begin errors++; $display("FAIL line_wrap_pix: got %h want 30", pix_data); end
   endtask

   task automatic test_host_bw();
      logic exp_r;
      logic exp_rv;
      exp_rv = 1'b0;
      drive_pos(100, 10);
      host_if.host_valid = 1'b1; host_if.host_we = 1'b0; host_if.host_addr = 15'd5;
      #1;
      for (int i = 0; i < 12; i++) begin
         exp_r = ((100 + i) % 4) != 2;
         checks++; if (host_if.host_ready !== exp_r) begin errors++; $display("FAIL bw_ready sx=%0d: got %b want %b", sx, host_if.host_ready, exp_r); end
         if (i > 0) begin
            checks++; if (host_if.host_rvalid !== exp_rv) begin errors++; $display("FAIL bw_rvalid sx=%0d: got %b want %b", sx, host_if.host_rvalid, exp_rv); end
         end
         exp_rv = exp_r;
         advance();
      end
      drive_pos(100, 490);
      #1;
      for (int i = 0; i < 8; i++) begin
         checks++; if (host_if.host_ready !== 1'b1) begin errors++; $display("FAIL blank_ready sx=%0d: got %b want 1", sx, host_if.host_ready); end
         advance();
      end
      host_if.host_valid = 1'b0;
      #1;
   endtask

   task automatic test_host_rw();
      drive_pos(700, 500);
      host_if.host_valid = 1'b1; host_if.host_we = 1'b1;
      host_if.host_addr = 15'd19199; host_if.host_wdata = 8'hA8;
      #1;
      checks++; if (mem_addr !== 15'd19199 || mem_en !== 1'b1) begin errors++; $display("FAIL wr_max: got en=%b addr=%0d want en=1 addr=19199", mem_en, mem_addr); end
      advance();
      host_if.host_we = 1'b0;
      #1;
      checks++; if ({mem_en, mem_we} !== 2'b10) begin errors++; $display("FAIL rd_strobe: got %b want 10", {mem_en, mem_we}); end
      advance();
      host_if.host_valid = 1'b0;
      #1;
      checks++; if ({host_if.host_rvalid, host_if.host_rdata} !== 9'h1A8) begin errors++; $display("FAIL rd_max: got %h want 1a8", {host_if.host_rvalid, host_if.host_rdata}); end
      host_if.host_valid = 1'b1; host_if.host_addr = 15'd19200;
      #1;
      checks++; if ({host_if.host_ready, mem_en} !== 2'b10) begin errors++; $display("FAIL rd_oor_req: got %b want 10", {host_if.host_ready, mem_en}); end
      advance();
      host_if.host_valid = 1'b0;
      #1;
      checks++; if ({host_if.host_rvalid, host_if.host_rdata} !== 9'h100) begin errors++; $display("FAIL rd_oor: got %h want 100", {host_if.host_rvalid, host_if.host_rdata}); end
      advance();
      checks++; if (host_if.host_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_pulse: got %b want 0", host_if.host_rvalid); end
      host_if.host_valid = 1'b1; host_if.host_we = 1'b1; host_if.host_wdata = 8'h11;
      #1;
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL wr_oor: got %b want 0", mem_en); end
      advance();
      host_if.host_valid = 1'b0; host_if.host_we = 1'b0;
      #1;
   endtask

   task automatic test_resync();
      drive_pos(300, 100);
      cfg_resync = 1'b1;
      host_if.host_valid = 1'b1; host_if.host_we = 1'b0; host_if.host_addr = 15'd2;
      #1;
      checks++; if (host_if.host_ready !== 1'b1) begin errors++; $display("FAIL rs_host_same: got %b want 1", host_if.host_ready); end
      advance();
      checks++; if (host_if.host_ready !== 1'b0) begin errors++; $display("FAIL r1_ready: got %b want 0", host_if.host_ready); end
      checks++; if ({mem_en, mem_we, mem_addr} !== 17'h10000) begin errors++; $display("FAIL r1_fetch: got %h want 10000", {mem_en, mem_we, mem_addr}); end
      checks++; if (pix_data[1:0] !== 2'b00) begin errors++; $display("FAIL r1_ctrl: got %b want 00", pix_data[1:0]); end
      checks++; if ({host_if.host_rvalid, host_if.host_rdata} !== 9'h157) begin errors++; $display("FAIL r1_rdata: got %h want 157", {host_if.host_rvalid, host_if.host_rdata}); end
      advance();
      checks++; if ({host_if.host_ready, mem_en} !== 2'b00) begin errors++; $display("FAIL r2_idle_bus: got %b want 00", {host_if.host_ready, mem_en}); end
      checks++; if (pix_data[1:0] !== 2'b11) begin errors++; $display("FAIL r2_ctrl: got %b want 11", pix_data[1:0]); end
      advance();
      cfg_resync = 1'b0; host_if.host_valid = 1'b0;
      #1;
      checks++; if ({sx, sy} !== 20'd0) begin errors++; $display("FAIL rs_origin: got %0d,%0d want 0,0", sx, sy); end
      checks++; if (pix_data !== 8'hFC) begin errors++; $display("FAIL rs_pix: got %h want fc", pix_data); end
      checks++; if (host_if.host_ready !== 1'b1) begin errors++; $display("FAIL rs_done_ready: got %b want 1", host_if.host_ready); end
   endtask

   task automatic test_enable();
      drive_pos(97, 20);
      #1;
      advance();
      checks++; if ({mem_en, mem_addr} !== {1'b1, 15'd825}) begin errors++; $display("FAIL en_fetch: got %b/%0d want 1/825", mem_en, mem_addr); end
      advance(); advance();
      checks++; if (pix_data !== 8'hE0) begin errors++; $display("FAIL en_pix: got %h want e0", pix_data); end
      cfg_enable = 1'b0;
      #1;
      advance(); advance();
      checks++; if ({mem_en, host_if.host_ready} !== 2'b01) begin errors++; $display("FAIL dis_slot: got %b want 01", {mem_en, host_if.host_ready}); end
      advance();
      checks++; if (pix_data !== 8'hE0) begin errors++; $display("FAIL dis_keep: got %h want e0", pix_data); end
      advance();
      checks++; if (pix_data !== 8'h00) begin errors++; $display("FAIL dis_black: got %h want 00", pix_data); end
      advance(); advance();
      checks++; if ({mem_en, host_if.host_ready} !== 2'b01) begin errors++; $display("FAIL dis_slot2: got %b want 01", {mem_en, host_if.host_ready}); end
      cfg_enable = 1'b1;
      #1;
   endtask

   task automatic test_reset_resync();
      drive_pos(200, 50);
      cfg_resync = 1'b1;
      host_if.host_valid = 1'b1; host_if.host_we = 1'b0; host_if.host_addr = 15'd2;
      #1;
      advance();
      cfg_resync = 1'b0; host_if.host_valid = 1'b0; rst_pix = 1'b1;
      #1;
      checks++; if (host_if.host_ready !== 1'b0) begin errors++; $display("FAIL rr_in_r1: got %b want 0", host_if.host_ready); end
      advance();
      rst_pix = 1'b0;
      #1;
      checks++; if ({pix_data, host_if.host_rvalid} !== 9'h000) begin errors++; $display("FAIL rr_after: got %h want 000", {pix_data, host_if.host_rvalid}); end
      advance();
      checks++; if ({sx, pix_data, host_if.host_ready} !== {10'd203, 8'h00, 1'b1}) begin errors++; $display("FAIL rr_idle: got sx=%0d pix=%h rdy=%b want 203/00/1", sx, pix_data, host_if.host_ready); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 19200; i++) ram[i] = 8'h00;
      test_reset();
      test_scanout();
      test_host_bw();
      test_host_rw();
      test_resync();
      test_enable();
      test_reset_resync();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
